// File: rtl/pkt_out_arbiter_if.sv
// pkt_out_arbiter_if: per-source packet ingress and single-stream egress of pkt_out_arbiter.
interface pkt_out_arbiter_if #(
  parameter int NUM_SRC = 2
);
  logic [NUM_SRC-1:0]     in_valid;
  logic [NUM_SRC*134-1:0] in_data;
  logic                   data_out_valid;
  logic [133:0]           data_out;
  logic [NUM_SRC-1:0]     drop_pulse;
  logic                   busy;
  modport master (
    output in_valid, in_data,
    input  data_out_valid, data_out, drop_pulse, busy
  );
  modport slave (
    input  in_valid, in_data,
    output data_out_valid, data_out, drop_pulse, busy
  );
endinterface

// File: rtl/pkt_out_arbiter.sv
// pkt_out_arbiter: buffers whole packets per source and emits them atomically, round-robin,
// or lowest-index-first when PKT_ARB_PRIO_EN is defined.
module pkt_out_arbiter #(
  parameter int NUM_SRC = 2,
  parameter int FIFO_AW = 6,
  parameter int CNT_W   = 4
) (
  input logic clk,
  input logic rst_n,
  pkt_out_arbiter_if.slave bus
);
  localparam int DW    = 134;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int SW    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  typedef logic [FIFO_AW-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef enum logic {IDLE, SEND} state_e;
  state_e state_q, state_d;
  logic [SW-1:0] src_q, src_d, gnt, idx, rd_src;
  logic [NUM_SRC-1:0] rdy, drop;
  logic [NUM_SRC-1:0][DW-1:0] rdata_a;
  logic [DW-1:0] rdata, dout_q;
  logic any_rdy, last, rd_en, busy, dvalid_q;
  assign any_rdy = |rdy;
  assign rdata   = rdata_a[src_q];
  assign last    = rdata[DW-1];
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    ptr_t wr_q, wr_d, cmt_q, cmt_d, rd_q, rd_d, base, nxt;
    cnt_t cnt_q, cnt_d;
    logic in_pkt_q, in_pkt_d, drop_q, acc, restart, full, we, rd, dec;
    logic [1:0] tag;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;
    assign tag     = bus.in_data[i*DW+132 +: 2];
    assign acc     = bus.in_valid[i] && (tag[0] || in_pkt_q);
    assign restart = acc && tag[0] && in_pkt_q;
    assign base    = restart ? cmt_q : wr_q;
    assign nxt     = base + 1'b1;
    // uncommitted words count toward fullness; a full FIFO or counter discards the whole packet
    assign full     = acc && (nxt == rd_q || (tag[1] && cnt_q == '1));
    assign we       = acc && !full;
    assign rd       = rd_en && rd_src == SW'(i);
    assign dec      = state_q == SEND && last && src_q == SW'(i);
    assign wr_d     = full ? cmt_q : we ? nxt : wr_q;
    assign cmt_d    = (we && tag[1]) ? nxt : cmt_q;
    assign in_pkt_d = full ? 1'b0 : we ? !tag[1] : in_pkt_q;
    assign cnt_d    = cnt_q + cnt_t'(we && tag[1]) - cnt_t'(dec);
    assign rd_d     = rd_q + ptr_t'(rd);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wr_q     <= '0;
        cmt_q    <= '0;
        rd_q     <= '0;
        cnt_q    <= '0;
        in_pkt_q <= 1'b0;
        drop_q   <= 1'b0;
      end else begin
        wr_q     <= wr_d;
        cmt_q    <= cmt_d;
        rd_q     <= rd_d;
        cnt_q    <= cnt_d;
        in_pkt_q <= in_pkt_d;
        drop_q   <= restart || full;
      end
    end
    always_ff @(posedge clk) begin
      if (we) mem[base] <= bus.in_data[i*DW +: DW];
      if (rd) rdata_q <= mem[rd_q];
    end
    assign rdy[i]     = cnt_q != '0;
    assign rdata_a[i] = rdata_q;
    assign drop[i]    = drop_q;
  end
`ifdef PKT_ARB_PRIO_EN
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = SW'(k);
      if (rdy[idx]) gnt = idx;
    end
  end
`else
  logic [SW-1:0] rr_q;
  // search from rr_q+1 upward; iterating backwards lets the first hit win
  always_comb begin
    gnt = rr_q;
    idx = '0;
    for (int k = NUM_SRC; k >= 1; k--) begin
      idx = SW'((int'(rr_q) + k) % NUM_SRC);
      if (rdy[idx]) gnt = idx;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_q <= SW'(NUM_SRC - 1);
    else if (state_q == IDLE && any_rdy) rr_q <= gnt;
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
    end
  end
  always_comb begin
    state_d = (state_q == IDLE) ? (any_rdy ? SEND : IDLE) : (last ? IDLE : SEND);
    src_d   = (state_q == IDLE && any_rdy) ? gnt : src_q;
  end
  // the grant cycle prefetches the head word; SEND keeps reading until the tail is in hand
  always_comb begin
    busy   = state_q == SEND;
    rd_en  = (state_q == IDLE) ? any_rdy : !last;
    rd_src = (state_q == IDLE) ? gnt : src_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvalid_q <= 1'b0;
      dout_q   <= '0;
    end else begin
      dvalid_q <= state_q == SEND;
      if (state_q == SEND) dout_q <= rdata;
    end
  end
  assign bus.data_out_valid = dvalid_q;
  assign bus.data_out       = dout_q;
  assign bus.drop_pulse     = drop;
  assign bus.busy           = busy;
endmodule

// File: doc/pkt_out_arbiter.md
Name: pkt_out_arbiter

Overview:
- Replaces the ad-hoc two-way output mux in the CPU user module.
- Buffers whole packets from NUM_SRC push-only 134-bit packet sources (e.g. config memory, packet SRAM, future DMA) in per-source FIFOs.
- Emits complete packets one at a time on a single output stream, round-robin, with no interleaving of words from different packets.
- Sits between packet-producing peripherals and the module's data_out port.

Parameters:
- NUM_SRC, 2, number of packet sources (2..4).
- FIFO_AW, 6, log2 of per-source FIFO depth in 134-bit words (depth 64).
- CNT_W, 4, width of the per-source complete-packet counter (max 15 buffered packets per source).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  NUM_SRC  per-source word strobe; bit i belongs to source i.
- in_data  in  NUM_SRC*134  per-source word, slice [i*134+:134]; bits [133:132] are the tag: 01 head, 00 body, 10 tail, 11 single-word packet (head+tail).
- data_out_valid  out  1  output word strobe, registered.
- data_out  out  134  output word, registered.
- drop_pulse  out  NUM_SRC  one-cycle pulse when a source's packet is discarded.
- busy  out  1  high while a packet is being emitted.

Behaviour:
- Reset: data_out_valid=0, data_out=0, drop_pulse=0, busy=0. All FIFO pointers, packet counters and in-packet flags are 0. Round-robin pointer is NUM_SRC-1, so source 0 wins first. State is IDLE.
- Reset is asynchronous and may arrive mid-packet: everything is cleared and partial packets are lost.

Per-source ingress (each source independent), all evaluated on an accepted in_valid word:
- wr_ptr advances on every accepted word. commit_ptr is updated to wr_ptr only when a tail is written.
- in_pkt is set by a head and cleared by a tail.
- Body or tail with in_pkt=0: word ignored, no drop_pulse.
- Head with in_pkt=1: wr_ptr rolls back to commit_ptr, drop_pulse asserts, and the new head is written.
- Word arriving when the FIFO is full (wr_ptr+1 == rd_ptr, counting uncommitted words): wr_ptr rolls back to commit_ptr, drop_pulse asserts, in_pkt clears, and the rest of that packet is ignored until the next head.
- Tail arriving when pkt_cnt == 2^CNT_W-1: treated exactly as the FIFO-full case.
- Tail or 11 word written: commit_ptr <= wr_ptr+1 and pkt_cnt++ in the same cycle. The packet becomes eligible the following cycle.
- Egress reads only up to commit_ptr. Uncommitted words are never emitted.

Egress FSM:
- IDLE: if any pkt_cnt>0, grant the first eligible source searching from rr_ptr+1 with wrap-around. Set rr_ptr to the grant and go to SEND. Otherwise stay in IDLE.
- SEND: emit one word per cycle from the granted FIFO, with data_out_valid=1 on consecutive cycles.
  - On the word whose tag is 10 or 11: decrement that source's pkt_cnt and return to IDLE.
  - If the source's ingress increments pkt_cnt in the same cycle, the net change is 0.
- busy=1 in SEND.
- Latency: eligibility in cycle t gives grant in t+1 and the first data_out_valid in t+2 (registered output).
- There is at least one idle cycle between consecutive output packets.
- Ingress and egress of the same FIFO may occur in the same cycle. FIFO storage has a registered read; the bench must not assume write-through.

Optional Feature:
- Macro PKT_ARB_PRIO_EN.
- Defined: fixed priority in IDLE; the lowest-index source with pkt_cnt>0 always wins and rr_ptr is unused.
- Undefined: round-robin as above.
- In both modes packets stay atomic.

Test Plan:
- Source 0 sends head, 2 body, tail (4 words) -> data_out_valid high for 4 consecutive cycles; first output word appears 2 cycles after eligibility; output tags are 01,00,00,10 and data matches the input; drop_pulse stays 0.
- Both sources each have 3 packets complete at once (round-robin build) -> output source order 0,1,0,1,0,1; every packet contiguous; one idle cycle between packets.
- Source 1 sends head, body, then a second head followed by body and tail -> drop_pulse[1] pulses once; only the second 3-word packet is output.
- FIFO_AW=3, source 0 sends a 10-word packet -> drop_pulse[0] on the 8th word; nothing is output; a following 3-word packet is then output intact.
- Source 0 sends a single word tagged 11 while a source 1 packet is being output -> the source 1 packet completes uninterrupted, then the 11 word follows after one idle cycle.
- rst_n asserted in SEND mid-packet -> data_out_valid=0 immediately (asynchronous); after release no residual words are output and busy=0.
- Build with PKT_ARB_PRIO_EN, source 0 continuously loaded -> source 1 packets are emitted only when pkt_cnt[0]=0.
